// File: rtl/lsu_dmem_ctrl.sv
// MEM-stage load/store controller: aligns B/H/W accesses onto a word-wide
// req/ack data-memory port, builds byte masks, flags misalignment and bus timeouts.
module lsu_dmem_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [2:0]        funct3_i,
    output logic              lsu_stall_o,
    output logic              lsu_done_o,
    output logic [31:0]       ld_data_tmp,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_bmask_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [1:0]        size;
        logic [1:0]        off;
        logic [3:0]        bmask;
        logic [31:0]       wdata;
    } acc_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    acc_t              acc_q, acc_d;
    logic [31:0]       ld_q, ld_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;
    logic              mreq_q, mreq_d;
    logic              mwe_q, mwe_d;
    logic [3:0]        bmask_q, bmask_d;

    logic [1:0]        req_off;
    logic [1:0]        req_size;
    logic              req_mis;
    logic [3:0]        req_bmask;
    logic [31:0]       ld_szmask;
    logic              unused_f3;

    assign req_off   = req_addr_i[1:0];
    assign req_size  = funct3_i[1:0];
    assign unused_f3 = funct3_i[2];

    // Request decode: misalignment and store lane mask
    always_comb begin
        req_mis   = 1'b0;
        req_bmask = 4'b0000;
        case (req_size)
            SZ_B: req_bmask = 4'b0001 << req_off;
            SZ_H: begin
                req_mis   = req_off[0];
                req_bmask = 4'b0011 << req_off;
            end
            SZ_W: begin
                req_mis   = (req_off != 2'b00);
                req_bmask = 4'b1111;
            end
            default: req_mis = 1'b1;
        endcase
    end

    // Zero-fill mask for the captured load, by latched access size
    always_comb begin
        ld_szmask = 32'hFFFF_FFFF;
        case (acc_q.size)
            SZ_B:    ld_szmask = 32'h0000_00FF;
            SZ_H:    ld_szmask = 32'h0000_FFFF;
            default: ld_szmask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ld_d    = ld_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_mis) begin
                        state_d = ERR;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d     = BUSY;
                        cnt_d       = '0;
                        acc_d.addr  = req_addr_i;
                        acc_d.we    = req_we_i;
                        acc_d.size  = req_size;
                        acc_d.off   = req_off;
                        acc_d.bmask = req_we_i ? req_bmask : 4'b0000;
                        acc_d.wdata = req_wdata_i << {req_off, 3'b000};
                    end
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (!acc_q.we) begin
                        ld_d = (mem_rdata_i >> {acc_q.off, 3'b000}) & ld_szmask;
                    end
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = ERR;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mreq_d  = (state_d == BUSY);
        mwe_d   = mreq_d & acc_d.we;
        bmask_d = mreq_d ? acc_d.bmask : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ld_q    <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
            bmask_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ld_q    <= ld_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
            mreq_q  <= mreq_d;
            mwe_q   <= mwe_d;
            bmask_q <= bmask_d;
        end
    end

    // Stall must rise in the request cycle itself, so it decodes req_valid_i directly
    assign lsu_stall_o = ((state_q == IDLE) && req_valid_i) || (state_q == BUSY);
    assign lsu_done_o  = done_q;
    assign misalign_o  = mis_q;
    assign bus_err_o   = berr_q;
    assign ld_data_tmp = ld_q;
    assign mem_req_o   = mreq_q;
    assign mem_we_o    = mwe_q;
    assign mem_bmask_o = bmask_q;
    assign mem_addr_o  = {acc_q.addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata_o = acc_q.wdata;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl with a short timeout and a scripted memory responder.
module tb_lsu_dmem_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_we_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [2:0]  funct3_i;
    logic        lsu_stall_o, lsu_done_o, misalign_o, bus_err_o;
    logic [31:0] ld_data_tmp;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_bmask_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    lsu_dmem_ctrl #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .funct3_i(funct3_i),
        .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o), .ld_data_tmp(ld_data_tmp),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_bmask_o(mem_bmask_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        logic        berr;
        int          done_cyc;
        int          req_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] model_ld = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One access; ack_cyc is the absolute cycle of the ack (0 = never acked)
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic [31:0] rdata, input int ack_cyc);
        logic [1:0]  size, off;
        logic        mis;
        logic [31:0] szmask, exp_wdata;
        logic [3:0]  exp_bmask;
        exp_t        e, g;
        int          req_seen;
        bit          done;
        size = f3[1:0];
        off  = addr[1:0];
        mis  = (size == 2'b11) || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
        szmask    = (size == 2'b00) ? 32'hFF : (size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        exp_wdata = wdata << (8 * off);
        exp_bmask = !we ? 4'b0000 : (size == 2'b00) ? (4'b0001 << off) :
                    (size == 2'b01) ? (4'b0011 << off) : 4'b1111;
        e.mis = mis; e.berr = 1'b0;
        if (mis) begin
            e.done_cyc = 1; e.req_cyc = 0;
        end else if (ack_cyc == 0) begin
            e.berr = 1'b1; e.done_cyc = TO + 1; e.req_cyc = TO;
        end else begin
            e.done_cyc = ack_cyc + 1; e.req_cyc = ack_cyc;
            if (!we) model_ld = (rdata >> (8 * off)) & szmask;
        end
        e.ld = model_ld;
        sb.push_back(e);
        req_seen = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
                req_wdata_i = wdata; funct3_i = f3; mem_rdata_i = rdata;
            end
            mem_ack_i = (ack_cyc != 0) && (cyc == ack_cyc);
            #1;
            if (mem_req_o) begin
                req_seen++;
                if (req_seen == 1) begin
                    check("mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
                    check("mem_we", 32'(mem_we_o), 32'(we));
                    check("mem_bmask", 32'(mem_bmask_o), 32'(exp_bmask));
                    if (we) check("mem_wdata", mem_wdata_o, exp_wdata);
                end
            end
            if (lsu_done_o) begin
                g = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(g.done_cyc));
                check("req_cycles", 32'(req_seen), 32'(g.req_cyc));
                check("ld_data", ld_data_tmp, g.ld);
                check("misalign", 32'(misalign_o), 32'(g.mis));
                check("bus_err", 32'(bus_err_o), 32'(g.berr));
                check("stall_on_done", 32'(lsu_stall_o), 32'h0);
                done = 1'b1;
                req_valid_i = 1'b0;
                mem_ack_i = 1'b0;
            end else begin
                check("stall_busy", 32'(lsu_stall_o), 32'h1);
            end
        end
        check("done_seen", 32'(done), 32'h1);
        if (!done) begin
            sb.delete();
            req_valid_i = 1'b0;
            mem_ack_i = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        funct3_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req_o), 32'h0);
        check("rst_done", 32'(lsu_done_o), 32'h0);
        check("rst_ld", ld_data_tmp, 32'h0);
        check("rst_stall", 32'(lsu_stall_o), 32'h0);
        check("rst_err", 32'({misalign_o, bus_err_o, mem_we_o}), 32'h0);
        check("rst_bmask", 32'(mem_bmask_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // lb with ack in 2nd BUSY cycle, then sh with immediate ack
        access(1'b0, 32'h0000_0103, 32'h0, 3'b000, 32'h1000_F0EE, 2);
        check("lb_value", ld_data_tmp, 32'h0000_0010);
        access(1'b1, 32'h0000_0102, 32'h1234_ABCD, 3'b001, 32'hDEAD_BEEF, 1);
        check("sh_ld_keep", ld_data_tmp, 32'h0000_0010);

        // misaligned and illegal-size accesses
        access(1'b0, 32'h0000_0102, 32'h0, 3'b010, 32'h0, 1);
        access(1'b0, 32'h0000_0101, 32'h0, 3'b001, 32'h0, 1);
        access(1'b1, 32'h0000_0100, 32'h5555_5555, 3'b011, 32'h0, 1);

        // timeout, ld_data_tmp held
        access(1'b0, 32'h0000_0200, 32'h0, 3'b010, 32'h0, 0);
        check("to_ld_keep", ld_data_tmp, 32'h0000_0010);

        // back-to-back lhu / lbu
        access(1'b0, 32'h0000_0002, 32'h0, 3'b101, 32'h1000_F0EE, 1);
        check("lhu_value", ld_data_tmp, 32'h0000_1000);
        access(1'b0, 32'h0000_0000, 32'h0, 3'b100, 32'h1000_F0EE, 1);
        check("lbu_value", ld_data_tmp, 32'h0000_00EE);

        for (int i = 0; i < 24; i++) begin
            access(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                   $urandom, (i % 8 == 7) ? 0 : int'($urandom_range(1, 3)));
        end

        // reset during BUSY aborts; late ack ignored
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h0000_0300; funct3_i = 3'b010;
        mem_ack_i = 1'b0;
        @(negedge clk); #1;
        check("abort_req_c1", 32'(mem_req_o), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid_i = 1'b0;
        #1;
        model_ld = 32'h0;
        check("abort_req_c3", 32'(mem_req_o), 32'h0);
        check("abort_done_c3", 32'(lsu_done_o), 32'h0);
        check("abort_ld", ld_data_tmp, model_ld);
        check("abort_stall", 32'(lsu_stall_o), 32'h0);
        @(negedge clk);
        mem_ack_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            #1;
            check("late_ack_done", 32'(lsu_done_o), 32'h0);
            check("late_ack_req", 32'(mem_req_o), 32'h0);
        end
        access(1'b0, 32'h0000_0001, 32'h0, 3'b100, 32'hA5C3_7E19, 1);
        check("post_abort_lbu", ld_data_tmp, 32'h0000_007E);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Load/store access controller in the MEM stage, directly upstream of the load extender. It aligns byte, half and word accesses onto a word-wide data-memory port with a req/ack handshake, generates store byte masks and detects misalignment. It runs a timeout on the memory port and holds the pipeline while an access is outstanding. It delivers the loaded data right-justified on ld_data_tmp, and the load extender sign/zero-extends it using funct3.

Parameters:
TIMEOUT_CYC, 255, max cycles in BUSY without mem_ack_i before bus error; 0 disables timeout
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid_i  in  1  MEM-stage access request; held stable until lsu_done_o
req_we_i  in  1  1 = store, 0 = load
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  32  store data (rs2), right-justified
funct3_i  in  3  RV32I funct3; [1:0] = size (00 B, 01 H, 10 W, 11 illegal); [2] ignored here
lsu_stall_o  out  1  freeze upstream pipeline
lsu_done_o  out  1  one-cycle completion pulse
ld_data_tmp  out  32  aligned load data, right-justified, zero-filled above access size
misalign_o  out  1  one-cycle pulse with lsu_done_o on misaligned/illegal access
bus_err_o  out  1  one-cycle pulse with lsu_done_o on timeout
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  word-aligned address (addr[1:0] forced 00)
mem_wdata_o  out  32  lane-shifted store data
mem_bmask_o  out  4  byte enables (bit i = byte i)
mem_ack_i  in  1  memory accepted/completed; rdata valid in same cycle
mem_rdata_i  in  32  read word

Behaviour:
- Reset (rst=1 at edge): state IDLE, timeout counter 0, ld_data_tmp 0, all other outputs 0. Reset during BUSY aborts the access: mem_req_o is low the following cycle, there is no done pulse and no write completes.
- off = req_addr_i[1:0]. Misaligned = (size H and off[0]=1) or (size W and off≠0) or size 11.
- FSM states: IDLE, BUSY, DONE, ERR.
  - IDLE: if req_valid_i and misaligned, go to ERR. If req_valid_i and aligned, latch addr, we, size, off, mask and shifted wdata, clear the counter, go to BUSY. Otherwise stay in IDLE.
  - BUSY: mem_req_o=1, with mem_addr_o, mem_we_o, mem_wdata_o and mem_bmask_o stable from latched values. If mem_ack_i=1: for a load, capture ld_data_tmp = mem_rdata_i >> (8*off); go to DONE. Else if TIMEOUT_CYC≠0 and counter==TIMEOUT_CYC-1, go to ERR with bus error flagged. Else increment the counter.
  - DONE: lsu_done_o=1; go to IDLE.
  - ERR: lsu_done_o=1 plus misalign_o or bus_err_o; no memory write; ld_data_tmp unchanged; go to IDLE.
- Store lane rules: mem_wdata_o = req_wdata_i << (8*off). mem_bmask_o = 0001<<off for B, 0011<<off for H, 1111 for W. mem_bmask_o = 0000 for loads. Outside BUSY, mem_bmask_o=0 and mem_we_o=0.
- lsu_stall_o = (IDLE and req_valid_i) or BUSY. It is low in DONE and ERR, so the pipeline advances on the done cycle.
- Latency: request seen in cycle 0; mem_req_o from cycle 1; ack in cycle k≥1; lsu_done_o in cycle k+1. Minimum 2 cycles. Misaligned access: done in cycle 1, and mem_req_o is never asserted.
- ld_data_tmp holds its value until the next successful load. Stores and errors never change it.
- mem_ack_i is ignored outside BUSY. One outstanding access only. A new request is sampled only in IDLE, so back-to-back accesses take at least 2 cycles each.
- Counter width is clog2(TIMEOUT_CYC+1), minimum 1.

Test Plan:
1. lb at 0x0000_0103, mem_rdata_i=0x1000_F0EE, ack in the 2nd BUSY cycle → mem_addr_o=0x0000_0100, mem_bmask_o=0000, lsu_done_o in cycle 3, ld_data_tmp=0x0000_0010, lsu_stall_o high in cycles 0–2.
2. sh at 0x0000_0102, wdata 0x1234_ABCD, immediate ack → mem_we_o=1, mem_bmask_o=1100, mem_wdata_o=0xABCD_0000, done in cycle 2, ld_data_tmp unchanged.
3. lw at 0x0000_0102 → misalign_o=1 and lsu_done_o=1 in cycle 1, mem_req_o never high, bus_err_o=0. lh at 0x0000_0101 → same response.
4. TIMEOUT_CYC=4, lw at 0x0000_0200, ack never arrives → mem_req_o high cycles 1–4, bus_err_o and lsu_done_o high in cycle 5, ld_data_tmp unchanged.
5. lw at 0x0000_0300 with no ack; assert rst in cycle 2 → mem_req_o=0 from cycle 3, no lsu_done_o, ld_data_tmp=0, state IDLE. A late mem_ack_i is ignored.
6. Back-to-back lhu at 0x0000_0002 (rdata 0x1000_F0EE), then lbu at 0x0000_0000 (rdata 0x1000_F0EE), immediate acks → ld_data_tmp=0x0000_1000, then 0x0000_00EE. Downstream with funct3=100 gives 0x0000_00EE.
